// File: rtl/npu_act_pkg.sv
// Shared activation-path constants: LUT geometry, saturation entry addresses
// and the table-load FSM state encoding.
package npu_act_pkg;

   localparam int LUT_ADDR_WIDTH = 5;
   localparam int LUT_DATA_WIDTH = 8;
   localparam int LUT_ENTRIES    = 18;
   localparam int LUT_OVF_ADDR   = 16;
   localparam int LUT_UDF_ADDR   = 17;

   typedef enum logic [1:0] {
      CFG_IDLE  = 2'd0,
      CFG_LOAD  = 2'd1,
      CFG_READY = 2'd2
   } cfg_state_e;

endpackage

// File: rtl/act_lut_cfg_fsm.sv
// Table-load sequencer: walks the entry index as config beats arrive and
// flags when the whole table holds a consistent image.
module act_lut_cfg_fsm
   import npu_act_pkg::*;
#(
   parameter int ADDR_WIDTH  = LUT_ADDR_WIDTH,
   parameter int LUT_ENTRIES = npu_act_pkg::LUT_ENTRIES
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_cfg_start,
   input  logic                  i_cfg_valid,
   output logic                  o_cfg_ready,
   output logic                  o_cfg_done,
   output logic                  o_tbl_valid,
   output logic                  o_wr_en,
   output logic [ADDR_WIDTH-1:0] o_wr_idx
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LUT_ENTRIES - 1);

   cfg_state_e            state_q;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic                  done_q;
   logic                  valid_q;

   assign o_cfg_ready = (state_q == CFG_LOAD);
   // A start in the same cycle wins over the beat, so the beat never lands.
   assign o_wr_en     = o_cfg_ready && i_cfg_valid && !i_cfg_start;
   assign o_wr_idx    = cnt_q;
   assign o_cfg_done  = done_q;
   assign o_tbl_valid = valid_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= CFG_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (i_cfg_start) begin
            state_q <= CFG_LOAD;
            cnt_q   <= '0;
            valid_q <= 1'b0;
         end else if (o_wr_en) begin
            if (cnt_q == LAST_IDX) begin
               state_q <= CFG_READY;
               cnt_q   <= '0;
               done_q  <= 1'b1;
               valid_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/act_lut_table.sv
// Programmable activation LUT: 16 bucket entries plus overflow/underflow
// saturation values, loaded by a config stream, read with one-cycle latency.
module act_lut_table
   import npu_act_pkg::*;
#(
   parameter int ADDR_WIDTH  = LUT_ADDR_WIDTH,
   parameter int DATA_WIDTH  = LUT_DATA_WIDTH,
   parameter int LUT_ENTRIES = npu_act_pkg::LUT_ENTRIES
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_cfg_start,
   input  logic                  i_cfg_valid,
   input  logic [DATA_WIDTH-1:0] i_cfg_data,
   output logic                  o_cfg_ready,
   output logic                  o_cfg_done,
   output logic                  o_tbl_valid,
   input  logic                  i_lut_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_lut_addr,
   output logic [DATA_WIDTH-1:0] o_act_dat,
   output logic                  o_act_vld,
   output logic                  o_lut_err
);

   localparam logic [ADDR_WIDTH:0] NUM_ENT = (ADDR_WIDTH + 1)'(LUT_ENTRIES);

   logic [DATA_WIDTH-1:0] mem_q [LUT_ENTRIES];
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_idx;
   logic [DATA_WIDTH-1:0] rd_val;
   logic                  rd_hit;
   logic [DATA_WIDTH-1:0] act_dat_q;
   logic                  act_vld_q;
   logic                  lut_err_q;

   act_lut_cfg_fsm #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .LUT_ENTRIES (LUT_ENTRIES)
   ) u_cfg_fsm (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_cfg_start (i_cfg_start),
      .i_cfg_valid (i_cfg_valid),
      .o_cfg_ready (o_cfg_ready),
      .o_cfg_done  (o_cfg_done),
      .o_tbl_valid (o_tbl_valid),
      .o_wr_en     (wr_en),
      .o_wr_idx    (wr_idx)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < LUT_ENTRIES; i++) mem_q[i] <= '0;
      end else begin
         for (int i = 0; i < LUT_ENTRIES; i++) begin
            if (wr_en && (wr_idx == ADDR_WIDTH'(i))) mem_q[i] <= i_cfg_data;
         end
      end
   end

   // Decoded mux keeps out-of-range addresses from indexing past the array.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < LUT_ENTRIES; i++) begin
         if (i_lut_addr == ADDR_WIDTH'(i)) rd_val = mem_q[i];
      end
   end

   assign rd_hit = o_tbl_valid && ({1'b0, i_lut_addr} < NUM_ENT);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         act_dat_q <= '0;
         act_vld_q <= 1'b0;
         lut_err_q <= 1'b0;
      end else begin
         act_vld_q <= i_lut_rd_en;
         lut_err_q <= i_lut_rd_en && !rd_hit;
         if (i_lut_rd_en) act_dat_q <= rd_hit ? rd_val : '0;
      end
   end

   assign o_act_dat = act_dat_q;
   assign o_act_vld = act_vld_q;
   assign o_lut_err = lut_err_q;

endmodule

// File: tb/tb_act_lut_table.sv
// Directed and randomized stimulus for act_lut_table against a table-image model.
module tb_act_lut_table;
   import npu_act_pkg::*;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_cfg_start = 1'b0;
   logic       i_cfg_valid = 1'b0;
   logic [7:0] i_cfg_data = '0;
   logic       o_cfg_ready, o_cfg_done, o_tbl_valid;
   logic       i_lut_rd_en = 1'b0;
   logic [4:0] i_lut_addr = '0;
   logic [7:0] o_act_dat;
   logic       o_act_vld, o_lut_err;

   act_lut_table dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_cfg_start (i_cfg_start),
      .i_cfg_valid (i_cfg_valid),
      .i_cfg_data  (i_cfg_data),
      .o_cfg_ready (o_cfg_ready),
      .o_cfg_done  (o_cfg_done),
      .o_tbl_valid (o_tbl_valid),
      .i_lut_rd_en (i_lut_rd_en),
      .i_lut_addr  (i_lut_addr),
      .o_act_dat   (o_act_dat),
      .o_act_vld   (o_act_vld),
      .o_lut_err   (o_lut_err)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   // Model: table image, whether a load is in progress, how many beats of it
   // have landed, and whether the image is complete.
   logic [7:0] m_mem [LUT_ENTRIES];
   bit         m_loading;
   bit         m_valid;
   int         m_beats;
   logic [7:0] m_last_dat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < LUT_ENTRIES; i++) m_mem[i] = 8'h00;
      m_loading  = 0;
      m_valid    = 0;
      m_beats    = 0;
      m_last_dat = 8'h00;
   endtask

   task automatic step(input bit st, input bit v, input logic [7:0] d,
                       input bit rd, input logic [4:0] a);
      logic [7:0] exp_dat;
      bit         exp_err, exp_done;
      i_cfg_start = st; i_cfg_valid = v; i_cfg_data = d;
      i_lut_rd_en = rd; i_lut_addr = a;
      chk("cfg_ready", 32'(o_cfg_ready), 32'(m_loading));
      exp_dat = m_last_dat;
      exp_err = 0;
      if (rd) begin
         if (m_valid && int'(a) < LUT_ENTRIES) exp_dat = m_mem[int'(a)];
         else begin exp_dat = 8'h00; exp_err = 1; end
      end
      exp_done = 0;
      if (st) begin
         m_loading = 1; m_valid = 0; m_beats = 0;
      end else if (m_loading && v) begin
         m_mem[m_beats] = d;
         m_beats++;
         if (m_beats == LUT_ENTRIES) begin
            m_loading = 0; m_valid = 1; exp_done = 1;
         end
      end
      m_last_dat = exp_dat;
      @(posedge i_clk); #1;
      if (o_cfg_done) done_cnt++;
      chk("act_vld",   32'(o_act_vld),   32'(rd));
      chk("act_dat",   32'(o_act_dat),   32'(exp_dat));
      chk("lut_err",   32'(o_lut_err),   32'(exp_err));
      chk("cfg_done",  32'(o_cfg_done),  32'(exp_done));
      chk("tbl_valid", 32'(o_tbl_valid), 32'(m_valid));
      i_cfg_start = 0; i_cfg_valid = 0; i_lut_rd_en = 0;
   endtask

   task automatic reset_outputs_chk();
      chk("rst_cfg_ready", 32'(o_cfg_ready), 0);
      chk("rst_cfg_done",  32'(o_cfg_done),  0);
      chk("rst_tbl_valid", 32'(o_tbl_valid), 0);
      chk("rst_act_dat",   32'(o_act_dat),   0);
      chk("rst_act_vld",   32'(o_act_vld),   0);
      chk("rst_lut_err",   32'(o_lut_err),   0);
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      #2;
      reset_outputs_chk();
      model_clear();
      i_cfg_start = 0; i_cfg_valid = 0; i_lut_rd_en = 0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
   endtask

   task automatic load_table(input logic [7:0] base, input bit use_rand);
      step(1, 0, 8'h00, 0, 5'd0);
      for (int k = 0; k < LUT_ENTRIES; k++)
         step(0, 1, use_rand ? 8'($urandom) : base + 8'(k), 0, 5'd0);
   endtask

   initial begin
      model_clear();
      // 1: reset state and a back-to-back load of 8'h10+k
      #3;
      do_reset();
      done_cnt = 0;
      load_table(8'h10, 0);
      chk("load1_done_count", 32'(done_cnt), 1);
      // 2: sweep all valid addresses back to back
      for (int a = 0; a < LUT_ENTRIES; a++) step(0, 0, 8'h00, 1, 5'(a));
      step(0, 0, 8'h00, 1, 5'(LUT_OVF_ADDR));
      step(0, 0, 8'h00, 1, 5'(LUT_UDF_ADDR));
      // 3: out-of-range reads, then an idle cycle to confirm o_act_dat holds
      step(0, 0, 8'h00, 1, 5'd18);
      step(0, 0, 8'h00, 1, 5'd31);
      step(0, 0, 8'h00, 1, 5'd2);
      step(0, 0, 8'h00, 0, 5'd7);

      // 4: read before any load, then a gappy load with a valid every third cycle
      do_reset();
      step(0, 0, 8'h00, 1, 5'd3);
      done_cnt = 0;
      step(1, 0, 8'h00, 0, 5'd0);
      for (int c = 0; c < 3 * LUT_ENTRIES; c++)
         step(0, (c % 3) == 2, 8'($urandom), 1, 5'($urandom_range(0, 31)));
      chk("gap_done_count", 32'(done_cnt), 1);
      for (int a = 0; a < LUT_ENTRIES; a++) step(0, 0, 8'h00, 1, 5'(a));

      // 5: restart after 7 beats with a concurrent beat, then 18 beats of 8'hA0+k
      done_cnt = 0;
      step(1, 0, 8'h00, 0, 5'd0);
      for (int k = 0; k < 7; k++) step(0, 1, 8'h55, 0, 5'd0);
      step(1, 1, 8'hEE, 0, 5'd0);
      for (int k = 0; k < LUT_ENTRIES; k++) step(0, 1, 8'hA0 + 8'(k), 0, 5'd0);
      chk("restart_done_count", 32'(done_cnt), 1);
      for (int a = 0; a < LUT_ENTRIES; a++) step(0, 0, 8'h00, 1, 5'(a));

      // 6: reset in the middle of a load, then reload
      step(1, 0, 8'h00, 0, 5'd0);
      for (int k = 0; k < 5; k++) step(0, 1, 8'h77, 0, 5'd0);
      do_reset();
      step(0, 0, 8'h00, 1, 5'd0);
      load_table(8'h00, 1);
      for (int a = 0; a < LUT_ENTRIES; a++) step(0, 0, 8'h00, 1, 5'(a));

      // Random traffic: sporadic restarts, random beats and random reads
      for (int n = 0; n < 400; n++)
         step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
              $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/act_lut_table.md
Name: act_lut_table

Overview:
Activation lookup table that responds to the 5-bit LUT address produced by the activation address generator.
- Holds 18 programmable 8-bit activation values:
  - entries 0..15: normal sign/magnitude buckets;
  - entry 16: overflow saturation value;
  - entry 17: underflow saturation value.
- A config stream loads the table under a small FSM.
- The read port returns the activation value one cycle after the address is presented.
- Sits in npu_core between the address generator and the activation output register.

Parameters:
ADDR_WIDTH, 5, LUT address width (matches address generator output)
DATA_WIDTH, 8, width of a LUT entry and of config data
LUT_ENTRIES, 18, number of valid entries (0..LUT_ENTRIES-1); must be <= 2**ADDR_WIDTH

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_cfg_start  input  1  single-cycle pulse: begin (re)loading the table from entry 0
i_cfg_valid  input  1  config beat valid
i_cfg_data  input  DATA_WIDTH  config beat payload (entry value)
o_cfg_ready  output  1  table accepts a config beat
o_cfg_done  output  1  single-cycle pulse: last entry written
o_tbl_valid  output  1  table fully loaded and usable
i_lut_rd_en  input  1  read request qualifier
i_lut_addr  input  ADDR_WIDTH  read address from address generator
o_act_dat  output  DATA_WIDTH  looked-up activation value
o_act_vld  output  1  o_act_dat valid
o_lut_err  output  1  single-cycle pulse: read was out of range or table not valid

Behaviour:
- Reset (async, i_rst_n=0):
  - FSM to IDLE; entry counter=0.
  - All table entries=0.
  - o_cfg_ready=0, o_cfg_done=0, o_tbl_valid=0, o_act_dat=0, o_act_vld=0, o_lut_err=0.
- FSM states IDLE, LOAD, READY.
  - IDLE: o_cfg_ready=0. i_cfg_start -> LOAD, counter=0.
  - LOAD: o_cfg_ready=1.
    - A beat is accepted when i_cfg_valid & o_cfg_ready; it writes entry[counter] and increments the counter.
    - Accepting entry LUT_ENTRIES-1 -> READY next cycle, counter=0, o_cfg_done=1 for exactly that cycle, o_tbl_valid=1 from that cycle on.
    - Gaps (i_cfg_valid=0) are allowed indefinitely.
  - READY: o_cfg_ready=0. i_cfg_start -> LOAD, o_tbl_valid drops to 0 the next cycle, counter=0.
- i_cfg_start has priority over a concurrent beat in every state:
  - In LOAD, start restarts the counter at 0 and the concurrent beat is discarded.
  - Entries already written keep their values until overwritten.
- Read port, latency 1:
  - If i_lut_rd_en is sampled high at edge N, o_act_vld=1 after edge N.
  - Otherwise o_act_vld=0 and o_act_dat holds its last value.
  - Hit condition: o_tbl_valid=1 and i_lut_addr < LUT_ENTRIES -> o_act_dat=entry[i_lut_addr].
  - Miss condition: o_tbl_valid=0 or i_lut_addr >= LUT_ENTRIES -> o_act_dat=0, o_lut_err=1 for that cycle, and o_act_vld still 1.
- Back-to-back reads every cycle are supported; no bubbles.
- Read and config write in the same cycle (only possible while o_tbl_valid=0) -> read reports a miss. There is no write-through.
- Unsigned compare for range check; no arithmetic on entry data.
- Reset mid-LOAD: table cleared; a new i_cfg_start is required before reads hit.

Decomposition:
- Shared package npu_act_pkg:
  - LUT_ENTRIES;
  - LUT_OVF_ADDR=16 and LUT_UDF_ADDR=17;
  - FSM state encoding (IDLE=2'd0, LOAD=2'd1, READY=2'd2).
- The address generator uses the same package addresses.
- One natural sub-module, act_lut_cfg_fsm: state, counter, o_cfg_ready/o_cfg_done/o_tbl_valid, write-enable and write-index outputs. The storage array and read pipeline stay in the top.

Test Plan:
1. Reset, then i_cfg_start, then 18 back-to-back beats with data 8'h10+k -> o_cfg_ready=1 during LOAD; o_cfg_done pulses one cycle after beat 17; o_tbl_valid=1.
2. After load, read addresses 0..17 every cycle -> o_act_dat=8'h10..8'h21 one cycle later, o_act_vld=1 continuously, o_lut_err=0.
3. Read addr 5'd18 and 5'd31 -> o_act_dat=0, o_act_vld=1, o_lut_err=1 for each.
4. Read addr 3 before any load -> o_act_dat=0, o_lut_err=1. Then interleave invalid gaps during load (valid every third cycle) -> all 18 entries written correctly.
5. i_cfg_start after 7 beats of a load, concurrent with a beat -> that beat discarded; the next 18 beats (data 8'hA0+k) land at entries 0..17; o_cfg_done pulses once.
6. Assert i_rst_n=0 mid-LOAD, release, then read addr 0 -> o_act_dat=0, o_lut_err=1, o_tbl_valid=0. Reload succeeds.
